noc_vc_output_arbiter: RTL and testbench
========================================

Name: noc_vc_output_arbiter

Overview:
- Sits directly downstream of the per-direction virtual channel FIFOs of one router output port.
- Each cycle, selects at most one non-empty VC that holds downstream credit, using round-robin.
- Pops one flit from the selected VC and registers it onto the output link, tagged with its VC id.
- Tracks per-VC credits returned by the downstream router's buffers.

Parameters:
- DATA_WIDTH, 32, flit width; must match the VC FIFO width.
- NUM_VC, 4, number of virtual channels arbitrated; legal values 2 or 4.
- CREDITS, 4, downstream buffer depth per VC; also the credit counter reset value; max 15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- vc_empty  in  NUM_VC  empty flag of each VC FIFO
- vc_rd_data  in  NUM_VC*DATA_WIDTH  combinational head flit of each VC; VC i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- vc_rd_en  out  NUM_VC  one-hot pop strobe to the VC FIFOs
- out_valid  out  1  output link flit valid
- out_data  out  DATA_WIDTH  output link flit
- out_vc  out  2  VC id of out_data
- credit_in  in  NUM_VC  one-cycle credit-return pulse per VC from downstream
- credit_err  out  1  sticky credit overflow flag
- credit_cnt  out  4*NUM_VC  current credit count per VC, for debug

Behaviour:
- Reset: already decided — reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - out_valid=0, out_data=0, out_vc=0, credit_err=0.
  - Every credit counter = CREDITS.
  - Round-robin pointer rr_ptr=0.
  - vc_rd_en=0, because eligibility is gated in reset.
- Eligibility: elig[i] = !vc_empty[i] && (credit[i] != 0).
- Grant (combinational):
  - Select the first eligible VC searching i = rr_ptr, rr_ptr+1, … mod NUM_VC.
  - vc_rd_en = one-hot of the grant, or 0 if nothing is eligible.
  - At most one bit set per cycle.
- Pop timing: the VC FIFO pops at the same edge that out_data captures vc_rd_data[grant].
- Output register, every edge:
  - If a grant exists: out_valid=1, out_data=head flit of the granted VC, out_vc=grant index.
  - Otherwise out_valid=0, and out_data/out_vc hold their previous value.
- Latency and throughput:
  - Flit appears on the link one cycle after vc_rd_en.
  - Sustained throughput is 1 flit/cycle.
  - There is no backpressure on the link; credits guarantee downstream space.
- Pointer update: after a grant to VC g, rr_ptr = (g+1) mod NUM_VC. With no grant, rr_ptr holds.
- Credit counter i, 4-bit, per cycle:
  - Send only: decrement.
  - credit_in[i] only: increment.
  - Both in the same cycle: unchanged.
  - Never decremented below 0; eligibility prevents a send at 0.
- Credit overflow:
  - Occurs when credit_in[i] arrives with credit[i]==CREDITS and no simultaneous send.
  - Counter stays at CREDITS (saturates) and credit_err sets.
  - credit_err clears only on reset.
- Reset mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - An in-flight out_valid drops in the same cycle.
  - Credits are restored to CREDITS; the downstream is expected to be reset together with this block.
- Fairness: any VC that is continuously eligible is granted within NUM_VC cycles.

Optional Feature:
- Macro: NOC_ARB_STATS_EN.
- When defined, adds two output ports:
  - stat_flits (32 bits): increments on every grant.
  - stat_stall (32 bits): increments on each cycle in which some VC is non-empty but no VC is eligible (credit starvation).
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
1. Reset, then VC0 only non-empty with head 0xA5A5_0001 -> vc_rd_en=0001 in the first active cycle; next cycle out_valid=1, out_data=0xA5A5_0001, out_vc=0; credit[0]=3.
2. All 4 VCs hold 3 flits each, credits=4, no credit_in -> grants VC0,1,2,3,0,1,2,3,0,1,2,3 back-to-back; out_valid=1 for 12 consecutive cycles; then all credits=1.
3. VC2 holds 6 flits, no credit_in -> exactly 4 flits sent, then credit[2]=0 and vc_rd_en=0; a credit_in[2] pulse -> one more flit sent 1 cycle after the credit register updates.
4. credit_in[1] and a grant to VC1 in the same cycle with credit[1]=2 -> credit[1] stays 2; credit_in[3] with credit[3]=4 and no send -> credit[3]=4, credit_err=1, and it remains 1 until reset.
5. Continuous traffic on all VCs, rst_n asserted mid-burst for 1 cycle -> out_valid=0 and vc_rd_en=0 immediately; after release, credits=4, rr_ptr=0, and the first grant goes to VC0.
6. With NOC_ARB_STATS_EN defined, rerun scenario 3 -> stat_flits=5 at the end; stat_stall equals the count of cycles in which VC2 was non-empty with credit[2]=0.

Source files
------------

// File: rtl/noc_vc_output_arbiter.sv
// Round-robin VC output arbiter with per-VC downstream credit tracking.
// Optional counters enabled by NOC_ARB_STATS_EN (stat_flits, stat_stall).
module noc_vc_output_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_VC     = 4,
  parameter int CREDITS    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_VC-1:0]            vc_empty,
  input  logic [NUM_VC*DATA_WIDTH-1:0] vc_rd_data,
  output logic [NUM_VC-1:0]            vc_rd_en,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [1:0]                   out_vc,
  input  logic [NUM_VC-1:0]            credit_in,
  output logic                         credit_err,
  output logic [4*NUM_VC-1:0]          credit_cnt
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [31:0]                  stat_flits,
  output logic [31:0]                  stat_stall
`endif
);

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  logic [3:0]        credit [NUM_VC];
  logic [NUM_VC-1:0] elig;
  logic [NUM_VC-1:0] ovf;
  logic [1:0]        rr_ptr;
  logic [1:0]        gnt_idx;
  logic              gnt_vld;

  // Eligibility is forced low during reset so no pop escapes.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      elig[i] = rst_n && !vc_empty[i] && (credit[i] != 4'd0);
    end
  end

  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = 2'((int'(rr_ptr) + k) % NUM_VC);
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    vc_rd_en = '0;
    if (gnt_vld) vc_rd_en[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= 2'((int'(gnt_idx) + 1) % NUM_VC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_vc    <= '0;
    end else begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= vc_rd_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        out_vc   <= gnt_idx;
      end
    end
  end

  for (genvar i = 0; i < NUM_VC; i++) begin : g_cred
    logic snd;
    logic ret;

    assign snd = vc_rd_en[i];
    assign ret = credit_in[i];
    assign ovf[i] = ret && !snd && (credit[i] == CRED_MAX);
    assign credit_cnt[4*i +: 4] = credit[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        credit[i] <= CRED_MAX;
      end else if (snd && !ret) begin
        credit[i] <= credit[i] - 4'd1;
      end else if (ret && !snd && !ovf[i]) begin
        credit[i] <= credit[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_err <= 1'b0;
    end else if (|ovf) begin
      credit_err <= 1'b1;
    end
  end

`ifdef NOC_ARB_STATS_EN
  logic starve;

  // Data waiting but every non-empty VC is out of credit.
  assign starve = (|(~vc_empty)) && !(|elig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_flits <= '0;
      stat_stall <= '0;
    end else begin
      if (gnt_vld) stat_flits <= stat_flits + 32'd1;
      if (starve)  stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_vc_output_arbiter.sv
// Directed bench for noc_vc_output_arbiter.
// Behavioural VC FIFO heads; checks at posedge + 2.
module tb_noc_vc_output_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  vc_empty;
  logic [127:0] vc_rd_data;
  logic [3:0]  vc_rd_en;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_vc;
  logic [3:0]  credit_in;
  logic        credit_err;
  logic [15:0] credit_cnt;
`ifdef NOC_ARB_STATS_EN
  logic [31:0] stat_flits;
  logic [31:0] stat_stall;
`endif

  int          fcnt [4];
  logic [31:0] fdat [4];
  int          checks;
  int          errors;

  noc_vc_output_arbiter #(
    .DATA_WIDTH(32),
    .NUM_VC(4),
    .CREDITS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vc_empty(vc_empty),
    .vc_rd_data(vc_rd_data),
    .vc_rd_en(vc_rd_en),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_vc(out_vc),
    .credit_in(credit_in),
    .credit_err(credit_err),
    .credit_cnt(credit_cnt)
`ifdef NOC_ARB_STATS_EN
    ,
    .stat_flits(stat_flits),
    .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    vc_empty   = '0;
    vc_rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      vc_empty[i] = (fcnt[i] == 0);
      vc_rd_data[i*32 +: 32] = fdat[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [3:0] pop;
    pop = vc_rd_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        fcnt[i] = fcnt[i] - 1;
        fdat[i] = fdat[i] + 32'd1;
      end
    end
    credit_in = '0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 4; i++) begin
      fcnt[i] = 0;
      fdat[i] = '0;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    credit_in = '0;
    clear_fifos();
    #7;

    // reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_vc", 64'(out_vc), 64'd0);
    check("rst_credit_err", 64'(credit_err), 64'd0);
    check("rst_credit_cnt", 64'(credit_cnt), 64'h4444);
    check("rst_rd_en", 64'(vc_rd_en), 64'd0);

    // 1: single flit on VC0
    fcnt[0] = 1;
    fdat[0] = 32'hA5A5_0001;
    do_reset();
    check("t1_rd_en", 64'(vc_rd_en), 64'h1);
    cyc();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", 64'(out_data), 64'hA5A5_0001);
    check("t1_vc", 64'(out_vc), 64'd0);
    check("t1_credit0", 64'(credit_cnt[3:0]), 64'd3);
    check("t1_rd_en_idle", 64'(vc_rd_en), 64'd0);

    // 2: all VCs 3 flits, round-robin back to back
    clear_fifos();
    for (int i = 0; i < 4; i++) begin
      fcnt[i] = 3;
      fdat[i] = {4'(i + 1), 28'h0};
    end
    do_reset();
    for (int k = 0; k < 12; k++) begin
      check("t2_rd_en", 64'(vc_rd_en), 64'(4'b0001 << (k % 4)));
      cyc();
      check("t2_valid", 64'(out_valid), 64'd1);
      check("t2_vc", 64'(out_vc), 64'(k % 4));
      check("t2_data", 64'(out_data),
            64'({4'((k % 4) + 1), 28'h0} + 32'(k / 4)));
    end
    check("t2_credits", 64'(credit_cnt), 64'h1111);
    check("t2_rd_en_done", 64'(vc_rd_en), 64'd0);
    cyc();
    check("t2_valid_drop", 64'(out_valid), 64'd0);
    check("t2_vc_hold", 64'(out_vc), 64'd3);
    check("t2_data_hold", 64'(out_data), 64'h4000_0002);

    // 3: VC2 credit exhaustion and one returned credit
    clear_fifos();
    fcnt[2] = 6;
    fdat[2] = 32'hC200_0000;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      check("t3_rd_en", 64'(vc_rd_en), 64'h4);
      cyc();
      check("t3_vc", 64'(out_vc), 64'd2);
      check("t3_data", 64'(out_data), 64'(32'hC200_0000 + 32'(k)));
    end
    check("t3_credit2_zero", 64'(credit_cnt[11:8]), 64'd0);
    check("t3_rd_en_blocked", 64'(vc_rd_en), 64'd0);
    cyc();
    check("t3_valid_stall", 64'(out_valid), 64'd0);
    cyc();
    credit_in = 4'b0100;
    cyc();
    check("t3_credit2_one", 64'(credit_cnt[11:8]), 64'd1);
    check("t3_rd_en_resume", 64'(vc_rd_en), 64'h4);
    cyc();
    check("t3_valid5", 64'(out_valid), 64'd1);
    check("t3_data5", 64'(out_data), 64'hC200_0004);
    check("t3_credit2_again", 64'(credit_cnt[11:8]), 64'd0);
`ifdef NOC_ARB_STATS_EN
    check("t6_stat_flits", 64'(stat_flits), 64'd5);
    check("t6_stat_stall", 64'(stat_stall), 64'd3);
`endif

    // 4: simultaneous send/return, then overflow
    clear_fifos();
    fcnt[1] = 3;
    fdat[1] = 32'hB100_0000;
    do_reset();
    cyc();
    cyc();
    check("t4_credit1_two", 64'(credit_cnt[7:4]), 64'd2);
    check("t4_rd_en_vc1", 64'(vc_rd_en), 64'h2);
    credit_in = 4'b0010;
    cyc();
    check("t4_credit1_same", 64'(credit_cnt[7:4]), 64'd2);
    check("t4_err_clear", 64'(credit_err), 64'd0);
    check("t4_vc1_sent", 64'(out_vc), 64'd1);
    credit_in = 4'b1000;
    cyc();
    check("t4_credit_sat", 64'(credit_cnt), 64'h4424);
    check("t4_err_set", 64'(credit_err), 64'd1);
    cyc();
    cyc();
    check("t4_err_sticky", 64'(credit_err), 64'd1);

    // 5: asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) begin
      fcnt[i] = 20;
      fdat[i] = {4'(i + 8), 28'h0};
    end
    cyc();
    cyc();
    cyc();
    check("t5_busy", 64'(out_valid), 64'd1);
    check("t5_err_before", 64'(credit_err), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 64'(out_valid), 64'd0);
    check("t5_async_rd_en", 64'(vc_rd_en), 64'd0);
    check("t5_async_credits", 64'(credit_cnt), 64'h4444);
    check("t5_async_err", 64'(credit_err), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("t5_rel_credits", 64'(credit_cnt), 64'h4444);
    check("t5_rel_rd_en", 64'(vc_rd_en), 64'h1);
    cyc();
    check("t5_first_valid", 64'(out_valid), 64'd1);
    check("t5_first_vc", 64'(out_vc), 64'd0);
    check("t5_next_rd_en", 64'(vc_rd_en), 64'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
